// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and its environment.
// The slave side is the sequencer and the master side is whoever drives the PLL status inputs.
interface pll_reset_sequencer_if #(
    parameter int LOSS_CNT_W = 8
);
    logic                  restart_in;
    logic                  pll_lock_in;
    logic                  pll_lock_stdy_in;
    logic                  pll_stdy_rst_out;
    logic                  ser_reset_out;
    logic                  pix_reset_out;
    logic                  video_en_out;
    logic                  locked_out;
    logic                  timeout_out;
    logic [LOSS_CNT_W-1:0] loss_count_out;
    logic [2:0]            state_out;

    modport master (
        output restart_in, pll_lock_in, pll_lock_stdy_in,
        input  pll_stdy_rst_out, ser_reset_out, pix_reset_out, video_en_out,
               locked_out, timeout_out, loss_count_out, state_out
    );

    modport slave (
        input  restart_in, pll_lock_in, pll_lock_stdy_in,
        output pll_stdy_rst_out, ser_reset_out, pix_reset_out, video_en_out,
               locked_out, timeout_out, loss_count_out, state_out
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Power-up / lock-loss sequencer for the video output PLL, clocked by the free-running reference.
// Holds serializer and pixel resets until lock is stable, then releases them in order.
module pll_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int PIX_RELEASE_DELAY   = 16,
    parameter int STDY_RST_CYCLES     = 4,
    parameter int LOSS_CNT_W          = 8
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    pll_reset_sequencer_if.slave  bus
);

    localparam int MAX_AB = (LOCK_STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                            LOCK_STABLE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CD = (PIX_RELEASE_DELAY > STDY_RST_CYCLES) ?
                            PIX_RELEASE_DELAY : STDY_RST_CYCLES;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] C_STDY_LAST = CNT_W'(STDY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_PIX_LAST  = CNT_W'(PIX_RELEASE_DELAY - 1);

    typedef enum logic [2:0] {
        S_CLR  = 3'd0,
        S_WAIT = 3'd1,
        S_STAB = 3'd2,
        S_SER  = 3'd3,
        S_RUN  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  r_lock_m, r_lock_s;
    logic                  r_stdy_m, r_stdy_s;
    logic                  r_stdy_rst;
    logic                  r_ser_rst;
    logic                  r_pix_rst;
    logic                  r_run;
    logic                  r_timeout;
    logic [LOSS_CNT_W-1:0] r_loss;
    logic                  w_loss_evt;
    logic                  w_timeout_evt;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_lock_m <= 1'b0;
            r_lock_s <= 1'b0;
            r_stdy_m <= 1'b0;
            r_stdy_s <= 1'b0;
        end else begin
            r_lock_m <= bus.pll_lock_in;
            r_lock_s <= r_lock_m;
            r_stdy_m <= bus.pll_lock_stdy_in;
            r_stdy_s <= r_stdy_m;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_loss_evt    = 1'b0;
        w_timeout_evt = 1'b0;
        if (bus.restart_in) begin
            w_next = S_CLR;
        end else begin
            case (r_state)
                // The pulse length counts only cycles where the pulse is actually high,
                // so the first cycle after reset (pulse still low) is not included.
                S_CLR: if (r_stdy_rst && (r_cnt == C_STDY_LAST)) w_next = S_WAIT;
                S_WAIT: begin
                    if (r_lock_s) begin
                        w_next = S_STAB;
                    end else if (r_cnt == C_TO_LAST) begin
                        w_next        = S_CLR;
                        w_timeout_evt = 1'b1;
                    end
                end
                S_STAB: begin
                    if (!r_lock_s)                 w_next = S_WAIT;
                    else if (!r_stdy_s)            w_next = S_CLR;
                    else if (r_cnt == C_STAB_LAST) w_next = S_SER;
                end
                S_SER: begin
                    if (!r_lock_s) begin
                        w_next     = S_CLR;
                        w_loss_evt = 1'b1;
                    end else if (r_cnt == C_PIX_LAST) begin
                        w_next = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!r_lock_s) begin
                        w_next     = S_CLR;
                        w_loss_evt = 1'b1;
                    end
                end
                default: w_next = S_CLR;
            endcase
        end
    end

    always_comb begin
        w_cnt_next = r_cnt + CNT_W'(1);
        if (bus.restart_in || (w_next != r_state)) begin
            w_cnt_next = '0;
        end else if ((r_state == S_CLR && !r_stdy_rst) || r_state == S_RUN) begin
            w_cnt_next = r_cnt;
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= S_CLR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_stdy_rst <= 1'b0;
            r_ser_rst  <= 1'b1;
            r_pix_rst  <= 1'b1;
            r_run      <= 1'b0;
            r_timeout  <= 1'b0;
            r_loss     <= '0;
        end else begin
            r_stdy_rst <= (w_next == S_CLR);
            r_ser_rst  <= !((w_next == S_SER) || (w_next == S_RUN));
            r_pix_rst  <= (w_next != S_RUN);
            r_run      <= (w_next == S_RUN);
            if (w_timeout_evt) begin
                r_timeout <= 1'b1;
            end else if ((w_next == S_SER) && (r_state != S_SER)) begin
                r_timeout <= 1'b0;
            end
            if (w_loss_evt && (r_loss != {LOSS_CNT_W{1'b1}})) begin
                r_loss <= r_loss + LOSS_CNT_W'(1);
            end
        end
    end

    assign bus.pll_stdy_rst_out = r_stdy_rst;
    assign bus.ser_reset_out    = r_ser_rst;
    assign bus.pix_reset_out    = r_pix_rst;
    assign bus.video_en_out     = r_run;
    assign bus.locked_out       = r_run;
    assign bus.timeout_out      = r_timeout;
    assign bus.loss_count_out   = r_loss;
    assign bus.state_out        = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer: hand-derived vector table, directed corner sequences,
// and randomized lock behaviour checked cycle by cycle against a phase/remaining-time model.
module tb_pll_reset_sequencer;

    localparam int STABLE  = 8;
    localparam int TIMEOUT = 64;
    localparam int PIX     = 4;
    localparam int STDY    = 2;
    localparam int LW      = 2;

    logic clk      = 1'b0;
    logic reset_in = 1'b0;

    pll_reset_sequencer_if #(.LOSS_CNT_W(LW)) bus ();

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES (STABLE),
        .LOCK_TIMEOUT_CYCLES(TIMEOUT),
        .PIX_RELEASE_DELAY  (PIX),
        .STDY_RST_CYCLES    (STDY),
        .LOSS_CNT_W         (LW)
    ) dut (
        .clock_in(clk),
        .reset_in(reset_in),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [10:0] exp_q[$];

    // Output vector: {stdy_rst, ser_rst, pix_rst, video_en, locked, timeout, loss[1:0], state[2:0]}
    function automatic logic [10:0] mk(int st, bit sr, bit se, bit px, bit rn, bit to, int ls);
        return {sr, se, px, rn, rn, to, 2'(ls), 3'(st)};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {bus.pll_stdy_rst_out, bus.ser_reset_out, bus.pix_reset_out, bus.video_en_out,
                bus.locked_out, bus.timeout_out, bus.loss_count_out, bus.state_out};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase number plus cycles remaining in that phase; the
    // synchroniser is a two-deep delay line.
    int m_phase, m_left, m_loss;
    bit m_stdy, m_to;
    bit pl[2], ps[2];

    function automatic int phase_len(int p);
        case (p)
            0: return STDY;
            1: return TIMEOUT;
            2: return STABLE;
            3: return PIX;
            default: return 0;
        endcase
    endfunction

    task automatic m_enter(int p);
        if (p == 3) m_to = 1'b0;
        m_phase = p;
        m_left  = phase_len(p);
    endtask

    task automatic model_reset();
        m_phase = 0; m_left = STDY; m_loss = 0; m_stdy = 0; m_to = 0;
        pl[0] = 0; pl[1] = 0; ps[0] = 0; ps[1] = 0;
    endtask

    task automatic model_step(bit r, bit l, bit s);
        bit ls, ss;
        ls = pl[1]; ss = ps[1];
        pl[1] = pl[0]; pl[0] = l;
        ps[1] = ps[0]; ps[0] = s;
        if (r) begin
            m_enter(0);
        end else begin
            case (m_phase)
                0: if (m_stdy) begin m_left--; if (m_left == 0) m_enter(1); end
                1: if (ls) m_enter(2);
                   else begin m_left--; if (m_left == 0) begin m_to = 1; m_enter(0); end end
                2: if (!ls) m_enter(1);
                   else if (!ss) m_enter(0);
                   else begin m_left--; if (m_left == 0) m_enter(3); end
                3: if (!ls) begin m_loss = (m_loss < 3) ? m_loss + 1 : 3; m_enter(0); end
                   else begin m_left--; if (m_left == 0) m_enter(4); end
                default: if (!ls) begin m_loss = (m_loss < 3) ? m_loss + 1 : 3; m_enter(0); end
            endcase
        end
        m_stdy = (m_phase == 0);
    endtask

    function automatic logic [10:0] model_vec();
        return mk(m_phase, m_stdy, !(m_phase == 3 || m_phase == 4), m_phase != 4,
                  m_phase == 4, m_to, m_loss);
    endfunction

    // One clock cycle: called at a negedge, returns at the next negedge.
    task automatic cycle(bit r, bit l, bit s);
        logic [10:0] e;
        bus.restart_in       = r;
        bus.pll_lock_in      = l;
        bus.pll_lock_stdy_in = s;
        @(posedge clk);
        model_step(r, l, s);
        exp_q.push_back(model_vec());
        #1;
        e = exp_q.pop_front();
        chk("model", 32'(dut_vec()), 32'(e));
        @(negedge clk);
    endtask

    task automatic do_reset(bit l, bit s);
        bus.restart_in       = 0;
        bus.pll_lock_in      = l;
        bus.pll_lock_stdy_in = s;
        reset_in = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_values", 32'(dut_vec()), 32'(mk(0, 0, 1, 1, 0, 0, 0)));
        reset_in = 1'b0;
    endtask

    task automatic wait_state(int target, int budget, bit l, bit s);
        int n = 0;
        while (bus.state_out != 3'(target) && n < budget) begin
            cycle(0, l, s);
            n++;
        end
        chk($sformatf("reach_state_%0d", target), 32'(bus.state_out), 32'(target));
    endtask

    typedef struct {
        bit          restart;
        bit          lock;
        bit          stdy;
        int          cycles;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        bit rl, rs;
        // Power-up with lock and steady-lock high, then one single-cycle lock drop in RUN.
        tbl[0]  = '{0, 1, 1, 2,  mk(0, 1, 1, 1, 0, 0, 0)};
        tbl[1]  = '{0, 1, 1, 1,  mk(1, 0, 1, 1, 0, 0, 0)};
        tbl[2]  = '{0, 1, 1, 1,  mk(2, 0, 1, 1, 0, 0, 0)};
        tbl[3]  = '{0, 1, 1, 7,  mk(2, 0, 1, 1, 0, 0, 0)};
        tbl[4]  = '{0, 1, 1, 1,  mk(3, 0, 0, 1, 0, 0, 0)};
        tbl[5]  = '{0, 1, 1, 3,  mk(3, 0, 0, 1, 0, 0, 0)};
        tbl[6]  = '{0, 1, 1, 1,  mk(4, 0, 0, 0, 1, 0, 0)};
        tbl[7]  = '{0, 0, 1, 1,  mk(4, 0, 0, 0, 1, 0, 0)};
        tbl[8]  = '{0, 1, 1, 1,  mk(4, 0, 0, 0, 1, 0, 0)};
        tbl[9]  = '{0, 1, 1, 1,  mk(0, 1, 1, 1, 0, 0, 1)};
        tbl[10] = '{0, 1, 1, 2,  mk(1, 0, 1, 1, 0, 0, 1)};
        tbl[11] = '{0, 1, 1, 13, mk(4, 0, 0, 0, 1, 0, 1)};

        do_reset(1, 1);
        for (int i = 0; i < 12; i++) begin
            repeat (tbl[i].cycles) cycle(tbl[i].restart, tbl[i].lock, tbl[i].stdy);
            chk($sformatf("table_%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
        end

        // Repeated lock losses saturate the loss counter.
        for (int k = 2; k <= 4; k++) begin
            cycle(0, 0, 1);
            wait_state(0, 6, 1, 1);
            chk("loss_count", 32'(bus.loss_count_out), 32'((k < 3) ? k : 3));
            wait_state(4, 100, 1, 1);
        end

        // Lock glitch while in STAB at stable count 5.
        cycle(1, 1, 1);
        wait_state(2, 20, 1, 1);
        repeat (3) cycle(0, 1, 1);
        cycle(0, 0, 1);
        repeat (2) cycle(0, 1, 1);
        chk("glitch_to_wait", 32'(bus.state_out), 32'd1);
        chk("glitch_no_loss", 32'(bus.loss_count_out), 32'd3);
        repeat (8) cycle(0, 1, 1);
        chk("stab_restarted", 32'(bus.state_out), 32'd2);
        cycle(0, 1, 1);
        chk("stab_to_ser", 32'(bus.state_out), 32'd3);

        // Restart in SER on the same edge the synced lock falls.
        cycle(0, 0, 1);
        cycle(0, 1, 1);
        cycle(1, 1, 1);
        chk("restart_wins", 32'(dut_vec()), 32'(mk(0, 1, 1, 1, 0, 0, 3)));

        // Asynchronous reset in RUN.
        wait_state(4, 100, 1, 1);
        reset_in = 1'b1;
        #1;
        chk("async_reset", 32'(dut_vec()), 32'(mk(0, 0, 1, 1, 0, 0, 0)));
        model_reset();
        @(negedge clk);
        reset_in = 1'b0;

        // Lock held low: periodic timeout, then recovery clears the flag at SER.
        do_reset(0, 1);
        repeat (66) cycle(0, 0, 1);
        chk("pre_timeout", 32'(dut_vec()), 32'(mk(1, 0, 1, 1, 0, 0, 0)));
        cycle(0, 0, 1);
        chk("timeout_1", 32'(dut_vec()), 32'(mk(0, 1, 1, 1, 0, 1, 0)));
        repeat (65) cycle(0, 0, 1);
        chk("wait_again", 32'(dut_vec()), 32'(mk(1, 0, 1, 1, 0, 1, 0)));
        cycle(0, 0, 1);
        chk("timeout_2", 32'(dut_vec()), 32'(mk(0, 1, 1, 1, 0, 1, 0)));
        wait_state(3, 200, 1, 1);
        chk("timeout_cleared", 32'(bus.timeout_out), 32'd0);
        wait_state(4, 50, 1, 1);

        // Randomized lock / steady-lock / restart behaviour against the model.
        do_reset(1, 1);
        rl = 1; rs = 1;
        for (int i = 0; i < 3000; i++) begin
            if (rl) rl = ($urandom_range(0, 99) >= 2);
            else    rl = ($urandom_range(0, 99) < 25);
            rs = ($urandom_range(0, 99) >= 2);
            cycle(($urandom_range(0, 199) == 0), rl, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
